// File: rtl/riscv_boot_ctrl.sv
// riscv_boot_ctrl: RV32I boot sequencer. It streams a length-prefixed image into IMEM, then releases the core reset.
// Optional feature macro BOOT_CHECKSUM_EN: a trailing 32-bit sum of the data words is verified before the core is released.
module riscv_boot_ctrl #(
  parameter int IMEM_ADDR_BIT = 12,
  parameter int RST_HOLD      = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_boot_start,
  input  logic [7:0]               i_rx_data,
  input  logic                     i_rx_valid,
  output logic                     o_rx_ready,
  output logic                     o_imem_wr_en,
  output logic [IMEM_ADDR_BIT-1:0] o_imem_wr_addr,
  output logic [31:0]              o_imem_wr_data,
  output logic                     o_core_rstn,
  output logic                     o_boot_busy,
  output logic                     o_boot_done,
  output logic                     o_boot_err
);
  localparam int          WIW = IMEM_ADDR_BIT - 1;
  localparam int          HCW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [31:0] CAP = 32'd1 << (IMEM_ADDR_BIT - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_HOLD, S_RUN, S_ERR
`ifdef BOOT_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t                   state_q, state_d;
  logic [1:0]               bcnt_q, bcnt_d;
  logic [23:0]              asm_q, asm_d;
  logic [WIW-1:0]           widx_q, widx_d;
  logic [WIW-1:0]           nlast_q, nlast_d;
  logic [HCW-1:0]           hcnt_q, hcnt_d;
  logic                     rx_ready_d, wr_en_d, core_rstn_d, busy_d, done_d, err_d;
  logic [IMEM_ADDR_BIT-1:0] wr_addr_d;
  logic [31:0]              wr_data_d;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0]              sum_q, sum_d;
`endif

  logic        xfer, word_done;
  logic [31:0] word;

  assign xfer      = i_rx_valid & o_rx_ready;
  assign word_done = xfer && (bcnt_q == 2'd3);
  // Last byte lands straight from the stream so the word is usable on its completing cycle
  assign word      = {i_rx_data, asm_q};

  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    asm_d       = asm_q;
    widx_d      = widx_q;
    nlast_d     = nlast_q;
    hcnt_d      = hcnt_q;
    rx_ready_d  = o_rx_ready;
    wr_en_d     = 1'b0;
    wr_addr_d   = o_imem_wr_addr;
    wr_data_d   = o_imem_wr_data;
    core_rstn_d = o_core_rstn;
    busy_d      = o_boot_busy;
    done_d      = o_boot_done;
    err_d       = o_boot_err;
`ifdef BOOT_CHECKSUM_EN
    sum_d       = sum_q;
`endif

    if (xfer) begin
      bcnt_d = bcnt_q + 2'd1;
      case (bcnt_q)
        2'd0:    asm_d[7:0]   = i_rx_data;
        2'd1:    asm_d[15:8]  = i_rx_data;
        2'd2:    asm_d[23:16] = i_rx_data;
        default: asm_d        = asm_q;
      endcase
    end

    case (state_q)
      S_IDLE, S_RUN, S_ERR: begin
        if (i_boot_start) begin
          state_d     = S_LEN;
          bcnt_d      = 2'd0;
          asm_d       = '0;
          widx_d      = '0;
          hcnt_d      = '0;
          rx_ready_d  = 1'b1;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          err_d       = 1'b0;
          core_rstn_d = 1'b0;
`ifdef BOOT_CHECKSUM_EN
          sum_d       = '0;
`endif
        end
      end
      S_LEN: begin
        if (word_done) begin
          if (word == 32'd0 || word > CAP) begin
            state_d    = S_ERR;
            rx_ready_d = 1'b0;
            busy_d     = 1'b0;
            err_d      = 1'b1;
          end else begin
            state_d = S_DATA;
            widx_d  = '0;
            nlast_d = WIW'(word - 32'd1);
          end
        end
      end
      S_DATA: begin
        if (word_done) begin
          wr_en_d   = 1'b1;
          wr_addr_d = IMEM_ADDR_BIT'({widx_q, 2'b00});
          wr_data_d = word;
`ifdef BOOT_CHECKSUM_EN
          sum_d     = sum_q + word;
`endif
          if (widx_q == nlast_q) begin
`ifdef BOOT_CHECKSUM_EN
            state_d    = S_CSUM;
`else
            state_d    = S_HOLD;
            rx_ready_d = 1'b0;
            hcnt_d     = '0;
`endif
          end else begin
            widx_d = widx_q + 1'b1;
          end
        end
      end
`ifdef BOOT_CHECKSUM_EN
      S_CSUM: begin
        if (word_done) begin
          rx_ready_d = 1'b0;
          if (word == sum_q) begin
            state_d = S_HOLD;
            hcnt_d  = '0;
          end else begin
            state_d = S_ERR;
            busy_d  = 1'b0;
            err_d   = 1'b1;
          end
        end
      end
`endif
      S_HOLD: begin
        // Release lands exactly RST_HOLD edges after the edge that took the last byte
        if (hcnt_q == HCW'(RST_HOLD - 1)) begin
          state_d     = S_RUN;
          core_rstn_d = 1'b1;
          done_d      = 1'b1;
          busy_d      = 1'b0;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        rx_ready_d  = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        core_rstn_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q        <= S_IDLE;
      bcnt_q         <= '0;
      asm_q          <= '0;
      widx_q         <= '0;
      nlast_q        <= '0;
      hcnt_q         <= '0;
      o_rx_ready     <= 1'b0;
      o_imem_wr_en   <= 1'b0;
      o_imem_wr_addr <= '0;
      o_imem_wr_data <= '0;
      o_core_rstn    <= 1'b0;
      o_boot_busy    <= 1'b0;
      o_boot_done    <= 1'b0;
      o_boot_err     <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      bcnt_q         <= bcnt_d;
      asm_q          <= asm_d;
      widx_q         <= widx_d;
      nlast_q        <= nlast_d;
      hcnt_q         <= hcnt_d;
      o_rx_ready     <= rx_ready_d;
      o_imem_wr_en   <= wr_en_d;
      o_imem_wr_addr <= wr_addr_d;
      o_imem_wr_data <= wr_data_d;
      o_core_rstn    <= core_rstn_d;
      o_boot_busy    <= busy_d;
      o_boot_done    <= done_d;
      o_boot_err     <= err_d;
`ifdef BOOT_CHECKSUM_EN
      sum_q          <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_riscv_boot_ctrl.sv
// tb_riscv_boot_ctrl: directed + randomized image loads checked against an image-level model of the boot protocol.
module tb_riscv_boot_ctrl;
  localparam int AW   = 12;
  localparam int HOLD = 4;
  localparam int CAP  = 1 << (AW - 2);

  logic          i_clk = 1'b0;
  logic          i_rstn = 1'b1;
  logic          i_boot_start = 1'b0;
  logic [7:0]    i_rx_data = '0;
  logic          i_rx_valid = 1'b0;
  logic          o_rx_ready, o_imem_wr_en, o_core_rstn, o_boot_busy, o_boot_done, o_boot_err;
  logic [AW-1:0] o_imem_wr_addr;
  logic [31:0]   o_imem_wr_data;

  riscv_boot_ctrl #(.IMEM_ADDR_BIT(AW), .RST_HOLD(HOLD)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_boot_start(i_boot_start),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
    .o_imem_wr_en(o_imem_wr_en), .o_imem_wr_addr(o_imem_wr_addr), .o_imem_wr_data(o_imem_wr_data),
    .o_core_rstn(o_core_rstn), .o_boot_busy(o_boot_busy), .o_boot_done(o_boot_done), .o_boot_err(o_boot_err)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  logic [7:0]    tx_q[$];
  logic [31:0]   img_w[$];
  logic [AW-1:0] got_a[$];
  logic [31:0]   got_d[$];
  int            n_assert = 0, n_fail = 0, last_acc = 0;

  always @(negedge i_clk)
    if (o_imem_wr_en === 1'b1) begin
      got_a.push_back(o_imem_wr_addr);
      got_d.push_back(o_imem_wr_data);
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) tx_q.push_back(w[8*b +: 8]);
  endtask

  task automatic start_boot();
    @(negedge i_clk); i_boot_start = 1'b1;
    @(negedge i_clk); i_boot_start = 1'b0;
  endtask

  // Drives tx_q; a byte counts as taken when valid & ready are both high at the edge following this negedge.
  task automatic send(input int gap, input bit starts);
    int idx = 0;
    int budget = 40 * tx_q.size() + 200;
    while (idx < tx_q.size() && budget > 0) begin
      @(negedge i_clk);
      budget--;
      i_rx_valid   = ($urandom_range(99) >= gap);
      i_rx_data    = tx_q[idx];
      i_boot_start = starts && ($urandom_range(7) == 0);
      if (i_rx_valid && o_rx_ready) begin
        idx++;
        last_acc = cyc + 1;
      end
    end
    @(negedge i_clk);
    i_rx_valid   = 1'b0;
    i_boot_start = 1'b0;
    chk("send_progress", idx, tx_q.size());
  endtask

  task automatic wait_release(input string tag);
    int rel = -1;
    for (int k = 0; k < 60; k++) begin
      if (o_core_rstn === 1'b1) begin rel = cyc; break; end
      @(negedge i_clk);
    end
    chk({tag, "_hold_cycles"}, rel - last_acc, HOLD);
  endtask

  task automatic check_writes(input string tag, input int n);
    chk({tag, "_wr_count"}, got_a.size(), n);
    for (int i = 0; i < n && i < got_a.size(); i++) begin
      chk({tag, "_wr_addr"}, 32'(got_a[i]), 32'(i * 4));
      chk({tag, "_wr_data"}, got_d[i], img_w[i]);
    end
  endtask

  // Image-level model: length rule, one write per word at i*4, optional sum check, then timed release.
  task automatic run_image(input string tag, input int gap, input bit starts, input logic [31:0] n,
                           input logic [31:0] sum_delta);
    bit          len_ok, ok;
    logic [31:0] sum;
    len_ok = (n != 0) && (n <= CAP);
    sum = 0;
    foreach (img_w[i]) sum += img_w[i];
    tx_q.delete();
    push_word(n);
    if (len_ok) begin
      foreach (img_w[i]) push_word(img_w[i]);
`ifdef BOOT_CHECKSUM_EN
      push_word(sum + sum_delta);
`endif
    end
    ok = len_ok;
`ifdef BOOT_CHECKSUM_EN
    if (sum_delta != 0) ok = 1'b0;
`endif
    got_a.delete();
    got_d.delete();
    send(gap, starts);
    if (ok) begin
      i_rx_valid = 1'b1;
      i_rx_data  = 8'hA5;
      wait_release(tag);
      chk({tag, "_done"}, o_boot_done, 1);
      chk({tag, "_busy"}, o_boot_busy, 0);
      repeat (3) @(negedge i_clk);
      chk({tag, "_trail_ready"}, o_rx_ready, 0);
      i_rx_valid = 1'b0;
    end else begin
      chk({tag, "_err"}, o_boot_err, 1);
      chk({tag, "_ready"}, o_rx_ready, 0);
      chk({tag, "_busy"}, o_boot_busy, 0);
      repeat (HOLD + 3) @(negedge i_clk);
      chk({tag, "_core_held"}, o_core_rstn, 0);
      chk({tag, "_err_sticky"}, o_boot_err, 1);
    end
    check_writes(tag, len_ok ? int'(n) : 0);
  endtask

  task automatic set_t2();
    img_w.delete();
    img_w.push_back(32'h0000_0013);
    img_w.push_back(32'h0010_0093);
    img_w.push_back(32'hDEAD_BEEF);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_err_clr"}, o_boot_err, 0);
    chk({tag, "_busy"}, o_boot_busy, 1);
    chk({tag, "_ready"}, o_rx_ready, 1);
  endtask

  initial begin
    int n;
    // T1: reset
    #1 i_rstn = 1'b0;
    @(negedge i_clk);
    chk("rst_ready", o_rx_ready, 0);
    chk("rst_wr_en", o_imem_wr_en, 0);
    chk("rst_wr_addr", 32'(o_imem_wr_addr), 0);
    chk("rst_wr_data", o_imem_wr_data, 0);
    chk("rst_core_rstn", o_core_rstn, 0);
    chk("rst_busy", o_boot_busy, 0);
    chk("rst_done", o_boot_done, 0);
    chk("rst_err", o_boot_err, 0);
    i_rstn = 1'b1;
    repeat (10) @(negedge i_clk);
    chk("idle_ready", o_rx_ready, 0);
    chk("idle_busy", o_boot_busy, 0);
    chk("idle_core_rstn", o_core_rstn, 0);

    // T2: basic image, continuous valid
    start_boot();
    chk("start_busy", o_boot_busy, 1);
    chk("start_ready", o_rx_ready, 1);
    set_t2();
    run_image("t2", 0, 1'b0, 3, 0);

    // T3: illegal lengths, then start clears err
    start_boot();
    img_w.delete();
    run_image("t3_n0", 0, 1'b0, 0, 0);
    start_boot();
    chk_cleared("t3_a");
    run_image("t3_big", 0, 1'b0, CAP + 1, 0);
    start_boot();
    chk_cleared("t3_b");
    set_t2();
    run_image("t3_recover", 30, 1'b0, 3, 0);

    // T4: valid gaps with ignored start pulses
    start_boot();
    run_image("t4", 50, 1'b1, 3, 0);

    // T5: restart from RUN
    @(negedge i_clk); i_boot_start = 1'b1;
    @(negedge i_clk); i_boot_start = 1'b0;
    chk("t5_core_rstn", o_core_rstn, 0);
    chk("t5_done", o_boot_done, 0);
    chk("t5_busy", o_boot_busy, 1);
    img_w.delete();
    img_w.push_back(32'h0000_0073);
    run_image("t5", 20, 1'b0, 1, 0);

    // random images
    for (int r = 0; r < 3; r++) begin
      start_boot();
      n = $urandom_range(12, 1);
      img_w.delete();
      for (int i = 0; i < n; i++) img_w.push_back($urandom);
      run_image("rand", 50, 1'b1, n, 0);
    end

    // full capacity: last word lands at the top address
    start_boot();
    img_w.delete();
    for (int i = 0; i < CAP; i++) img_w.push_back($urandom);
    run_image("cap", 0, 1'b0, CAP, 0);

`ifdef BOOT_CHECKSUM_EN
    // T6: bad checksum keeps core held
    start_boot();
    set_t2();
    run_image("t6_bad", 0, 1'b0, 3, 1);
    start_boot();
    run_image("t6_ok", 10, 1'b0, 3, 0);
`endif

    // async reset mid-image
    start_boot();
    set_t2();
    tx_q.delete();
    push_word(3);
    push_word(img_w[0]);
    while (tx_q.size() > 7) void'(tx_q.pop_back());
    got_a.delete();
    got_d.delete();
    send(0, 1'b0);
    i_rx_valid = 1'b1;
    i_rx_data  = 8'h00;
    #2 i_rstn = 1'b0;
    #1;
    chk("arst_wr_en", o_imem_wr_en, 0);
    chk("arst_ready", o_rx_ready, 0);
    chk("arst_core_rstn", o_core_rstn, 0);
    chk("arst_busy", o_boot_busy, 0);
    repeat (3) @(negedge i_clk);
    chk("arst_no_write", got_a.size(), 0);
    i_rx_valid = 1'b0;
    i_rstn = 1'b1;
    start_boot();
    run_image("arst_recover", 0, 1'b0, 3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
